// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction-fetch front end.
//   - SEL_PC_* : next-PC source encodings emitted by the control unit.
//   - fetch_state_e : fetch FSM states (IDLE, REQ, WAIT, HOLD).
//   - WORD_ALIGN_MASK : clears the byte-offset bits of a PC.
package fetch_unit_pkg;

  localparam int SEL_PC_WIDTH = 3;

  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_NONE   = 3'd0;
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4   = 3'd1;
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JUMP   = 3'd2;
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_BRANCH = 3'd3;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_gen.sv
// next_pc_gen
//   Combinational next-PC selection for the fetch unit.
//   Ports:
//     in_hold     - fetch FSM is in HOLD (the only state that may advance)
//     flush       - redirect request; overrides every other source
//     flush_pc    - redirect target
//     pc          - current architectural PC
//     fetch_stall - control stall; blocks advancing
//     pc_sel      - next-PC source from control
//     br_taken    - branch outcome, qualifies SEL_PC_BRANCH
//     next_pc     - jump/branch target from control
//     advance     - HOLD may load target and start the next fetch
//     target      - word-aligned value to load into the PC
module next_pc_gen
  import fetch_unit_pkg::*;
(
  input  logic                    in_hold,
  input  logic                    flush,
  input  logic [31:0]             flush_pc,
  input  logic [31:0]             pc,
  input  logic                    fetch_stall,
  input  logic [SEL_PC_WIDTH-1:0] pc_sel,
  input  logic                    br_taken,
  input  logic [31:0]             next_pc,
  output logic                    advance,
  output logic [31:0]             target
);

  logic [31:0] pc_plus4;
  logic [31:0] sel_pc;
  logic        sel_hold;

  // 32-bit add wraps naturally, so 0xFFFF_FFFC + 4 becomes 0.
  assign pc_plus4 = pc + 32'd4;

  // Unknown encodings behave like NONE: the held instruction stays put.
  always_comb begin
    sel_hold = 1'b0;
    sel_pc   = pc_plus4;
    case (pc_sel)
      SEL_PC_NONE:   sel_hold = 1'b1;
      SEL_PC_ADD4:   sel_pc   = pc_plus4;
      SEL_PC_JUMP:   sel_pc   = next_pc;
      SEL_PC_BRANCH: sel_pc   = br_taken ? next_pc : pc_plus4;
      default:       sel_hold = 1'b1;
    endcase
  end

  always_comb begin
    advance = in_hold && !flush && !fetch_stall && !sel_hold;
    target  = (flush ? flush_pc : sel_pc) & WORD_ALIGN_MASK;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch front end. Owns the PC, issues one outstanding word
//   request at a time on a req/gnt/rvalid memory port and holds the fetched
//   instruction for the datapath until control steers the next fetch.
//   Ports:
//     clk, rst        - clock; synchronous active-low reset
//     fetch_stall_i   - control stall, blocks PC advance in HOLD
//     pc_sel_i        - next-PC source (SEL_PC_*)
//     br_taken_i      - branch outcome for SEL_PC_BRANCH
//     next_pc_i       - jump/branch target
//     flush_i         - redirect request, highest priority
//     flush_pc_i      - redirect target
//     imem_req_o      - request valid (state REQ)
//     imem_addr_o     - word address (always the current PC)
//     imem_gnt_i      - request accepted
//     imem_rvalid_i   - response valid
//     imem_rdata_i    - response instruction word
//     pc_o, ir_o      - held instruction and its PC
//     ir_valid_o      - ir_o/pc_o valid
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_stall_i,
  input  logic [SEL_PC_WIDTH-1:0] pc_sel_i,
  input  logic                    br_taken_i,
  input  logic [31:0]             next_pc_i,
  input  logic                    flush_i,
  input  logic [31:0]             flush_pc_i,
  output logic                    imem_req_o,
  output logic [31:0]             imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [31:0]             imem_rdata_i,
  output logic [31:0]             pc_o,
  output logic [31:0]             ir_o,
  output logic                    ir_valid_o
);

  fetch_state_e state_q, state_n;
  logic [31:0]  pc_q, pc_n;
  logic [31:0]  ir_q, ir_n;
  logic         ir_valid_q, ir_valid_n;
  // kill_q marks the outstanding response as stale after a flush.
  logic         kill_q, kill_n;

  logic         advance;
  logic [31:0]  target;

  next_pc_gen u_next_pc_gen (
    .in_hold     (state_q == FETCH_HOLD),
    .flush       (flush_i),
    .flush_pc    (flush_pc_i),
    .pc          (pc_q),
    .fetch_stall (fetch_stall_i),
    .pc_sel      (pc_sel_i),
    .br_taken    (br_taken_i),
    .next_pc     (next_pc_i),
    .advance     (advance),
    .target      (target)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC & WORD_ALIGN_MASK;
      ir_q       <= NOP_INSN;
      ir_valid_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      ir_q       <= ir_n;
      ir_valid_q <= ir_valid_n;
      kill_q     <= kill_n;
    end
  end

  // A flush or a HOLD advance loads the PC and invalidates the held word;
  // the state-specific part only decides where the FSM goes and whether the
  // in-flight response must be dropped.
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    ir_n       = ir_q;
    ir_valid_n = ir_valid_q;
    kill_n     = kill_q;

    if (flush_i || advance) begin
      pc_n       = target;
      ir_valid_n = 1'b0;
    end

    case (state_q)
      FETCH_IDLE: state_n = FETCH_REQ;

      FETCH_REQ: begin
        if (imem_gnt_i) begin
          state_n = FETCH_WAIT;
          kill_n  = flush_i;
        end
      end

      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          kill_n = 1'b0;
          if (flush_i || kill_q) begin
            state_n = FETCH_REQ;
          end else begin
            state_n    = FETCH_HOLD;
            ir_n       = imem_rdata_i;
            ir_valid_n = 1'b1;
          end
        end else if (flush_i) begin
          kill_n = 1'b1;
        end
      end

      FETCH_HOLD: begin
        if (flush_i || advance) state_n = FETCH_REQ;
      end

      default: state_n = FETCH_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = (state_q == FETCH_REQ);
    imem_addr_o = pc_q;
    pc_o        = pc_q;
    ir_valid_o  = ir_valid_q;
    ir_o        = ir_valid_q ? ir_q : NOP_INSN;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit: a vector table of PC-steering actions
//   with hand-computed fetch addresses, plus hand-written sequences for
//   stall, unknown select, flush and reset corner cases.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    fetch_stall = 1'b0;
  logic [SEL_PC_WIDTH-1:0] pc_sel = SEL_PC_NONE;
  logic                    br_taken = 1'b0;
  logic [31:0]             next_pc = 32'd0;
  logic                    flush = 1'b0;
  logic [31:0]             flush_pc = 32'd0;
  logic                    imem_req;
  logic [31:0]             imem_addr;
  logic                    imem_gnt = 1'b0;
  logic                    imem_rvalid = 1'b0;
  logic [31:0]             imem_rdata = 32'd0;
  logic [31:0]             pc_out;
  logic [31:0]             ir_out;
  logic                    ir_valid;

  int tests_run = 0;
  int tests_failed = 0;
  int last_wait = 0;

  typedef struct {
    logic [SEL_PC_WIDTH-1:0] sel;
    logic                    br;
    logic [31:0]             npc;
    int                      gnt_delay;
    logic [31:0]             rdata;
    logic [31:0]             exp_addr;
  } vec_t;

  vec_t vecs [7];

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSN (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_stall_i (fetch_stall),
    .pc_sel_i      (pc_sel),
    .br_taken_i    (br_taken),
    .next_pc_i     (next_pc),
    .flush_i       (flush),
    .flush_pc_i    (flush_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .pc_o          (pc_out),
    .ir_o          (ir_out),
    .ir_valid_o    (ir_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic [SEL_PC_WIDTH-1:0] sel,
                               input logic br, input logic [31:0] npc);
    fetch_stall = stall;
    pc_sel      = sel;
    br_taken    = br;
    next_pc     = npc;
  endtask

  // Serves one fetch: waits (bounded) for a request, grants after gnt_delay
  // extra cycles, returns rdata the cycle after grant and checks the result.
  task automatic fetchWord(input string name, input logic [31:0] exp_addr,
                           input int gnt_delay, input logic [31:0] rdata);
    int n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    checkOutput({name, " req seen"}, {31'd0, imem_req}, 32'd1);
    if (!imem_req) return;
    checkOutput({name, " addr"}, imem_addr, exp_addr);
    for (int d = 0; d < gnt_delay; d++) begin
      @(negedge clk);
      checkOutput({name, " req held"}, {31'd0, imem_req}, 32'd1);
      checkOutput({name, " addr held"}, imem_addr, exp_addr);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    checkOutput({name, " req dropped"}, {31'd0, imem_req}, 32'd0);
    checkOutput({name, " valid low in wait"}, {31'd0, ir_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkOutput({name, " ir_valid"}, {31'd0, ir_valid}, 32'd1);
    checkOutput({name, " ir"}, ir_out, rdata);
    checkOutput({name, " pc"}, pc_out, exp_addr);
  endtask

  initial begin
    vecs[0] = '{SEL_PC_ADD4,   1'b0, 32'h0000_0000, 3, 32'h0010_0113, 32'h0000_0004};
    vecs[1] = '{SEL_PC_BRANCH, 1'b1, 32'h0000_0080, 0, 32'h1111_1111, 32'h0000_0080};
    vecs[2] = '{SEL_PC_BRANCH, 1'b0, 32'h0000_0200, 1, 32'h2222_2222, 32'h0000_0084};
    vecs[3] = '{SEL_PC_JUMP,   1'b0, 32'h0000_0103, 0, 32'h3333_3333, 32'h0000_0100};
    vecs[4] = '{SEL_PC_JUMP,   1'b0, 32'hFFFF_FFFC, 0, 32'h4444_4444, 32'hFFFF_FFFC};
    vecs[5] = '{SEL_PC_ADD4,   1'b0, 32'h0000_0000, 0, 32'h5555_5555, 32'h0000_0000};
    vecs[6] = '{SEL_PC_BRANCH, 1'b1, 32'h0000_0041, 2, 32'h7777_7777, 32'h0000_0040};

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("reset req", {31'd0, imem_req}, 32'd0);
    checkOutput("reset addr", imem_addr, 32'h0);
    checkOutput("reset ir", ir_out, NOP);
    checkOutput("reset valid", {31'd0, ir_valid}, 32'd0);

    // First fetch: request right after IDLE, instruction valid 3 cycles later.
    rst = 1'b1;
    @(negedge clk);
    fetchWord("first", 32'h0, 0, 32'h0050_0093);
    checkOutput("first latency", last_wait, 0);

    // Table: steer one cycle in HOLD, then serve the resulting fetch.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, vecs[i].sel, vecs[i].br, vecs[i].npc);
      @(negedge clk);
      applyStimulus(1'b0, SEL_PC_NONE, 1'b0, 32'd0);
      fetchWord($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].gnt_delay, vecs[i].rdata);
      checkOutput($sformatf("vec%0d wait", i), last_wait, 0);
    end

    // Unknown select encoding holds.
    applyStimulus(1'b0, 3'd5, 1'b1, 32'h0000_0900);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("unknown sel req", {31'd0, imem_req}, 32'd0);
      checkOutput("unknown sel pc", pc_out, 32'h0000_0040);
    end

    // Stall holds despite ADD4.
    applyStimulus(1'b1, SEL_PC_ADD4, 1'b0, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall req", {31'd0, imem_req}, 32'd0);
      checkOutput("stall pc", pc_out, 32'h0000_0040);
      checkOutput("stall ir", ir_out, 32'h7777_7777);
      checkOutput("stall valid", {31'd0, ir_valid}, 32'd1);
    end
    applyStimulus(1'b0, SEL_PC_ADD4, 1'b0, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, SEL_PC_NONE, 1'b0, 32'd0);
    fetchWord("after stall", 32'h0000_0044, 0, 32'h8888_8888);

    // Flush while WAIT: stale response dropped, refetch at 0x200.
    applyStimulus(1'b0, SEL_PC_ADD4, 1'b0, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, SEL_PC_NONE, 1'b0, 32'd0);
    checkOutput("pre-flush addr", imem_addr, 32'h0000_0048);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h0000_0200;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("wait flush valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("wait flush req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkOutput("killed valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("killed ir", ir_out, NOP);
    checkOutput("killed req", {31'd0, imem_req}, 32'd1);
    fetchWord("post flush", 32'h0000_0200, 0, 32'h9999_9999);

    // Flush in HOLD beats stall; then flush in REQ without grant.
    applyStimulus(1'b1, SEL_PC_ADD4, 1'b0, 32'd0);
    flush    = 1'b1;
    flush_pc = 32'h0000_0303;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, SEL_PC_NONE, 1'b0, 32'd0);
    checkOutput("hold flush req", {31'd0, imem_req}, 32'd1);
    checkOutput("hold flush addr", imem_addr, 32'h0000_0300);
    checkOutput("hold flush valid", {31'd0, ir_valid}, 32'd0);
    flush    = 1'b1;
    flush_pc = 32'h0000_0400;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("req flush req", {31'd0, imem_req}, 32'd1);
    checkOutput("req flush addr", imem_addr, 32'h0000_0400);
    fetchWord("req flush", 32'h0000_0400, 0, 32'hAAAA_AAAA);

    // Flush in REQ with a same-cycle grant: granted response is stale.
    applyStimulus(1'b0, SEL_PC_ADD4, 1'b0, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, SEL_PC_NONE, 1'b0, 32'd0);
    imem_gnt = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h0000_0500;
    @(negedge clk);
    imem_gnt = 1'b0;
    flush    = 1'b0;
    checkOutput("gnt flush req", {31'd0, imem_req}, 32'd0);
    checkOutput("gnt flush addr", imem_addr, 32'h0000_0500);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkOutput("gnt flush killed valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("gnt flush refetch req", {31'd0, imem_req}, 32'd1);
    fetchWord("gnt flush", 32'h0000_0500, 0, 32'hBBBB_BBBB);

    // Reset mid-WAIT with a response arriving during reset.
    applyStimulus(1'b0, SEL_PC_ADD4, 1'b0, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, SEL_PC_NONE, 1'b0, 32'd0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADB_AD00;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkOutput("mid reset req", {31'd0, imem_req}, 32'd0);
    checkOutput("mid reset addr", imem_addr, 32'h0);
    checkOutput("mid reset ir", ir_out, NOP);
    checkOutput("mid reset valid", {31'd0, ir_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    fetchWord("after reset", 32'h0, 0, 32'hCCCC_CCCC);
    checkOutput("after reset wait", last_wait, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
